// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int   BEATS  = 4;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant selection between requesters A and B.
// DMEM_ARB_RR_EN defined: ties go to the pointer port; otherwise A always wins ties.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic prio_port,
  output logic grant_vld,
  output logic grant_port
);

`ifndef DMEM_ARB_RR_EN
  logic unused_prio;
  assign unused_prio = prio_port;
`endif

  always_comb begin
    grant_vld  = a_req | b_req;
    grant_port = PORT_A;
    if (a_req && b_req) begin
`ifdef DMEM_ARB_RR_EN
      grant_port = prio_port;
`else
      grant_port = PORT_A;
`endif
    end else if (b_req) begin
      grant_port = PORT_B;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates 32-bit word loads/stores from A and B onto a byte-wide memory, 4 big-endian beats.
// Optional round-robin arbitration via DMEM_ARB_RR_EN (default: fixed priority to A).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  output logic [31:0]       a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  output logic [31:0]       b_rdata,
  output logic              b_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] beat);
    return word[{~beat, 3'b000} +: 8];
  endfunction

  state_t            state;
  logic [1:0]        beat;
  logic [1:0]        next_beat;
  logic              port_q;
  logic              prio_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       word_done;

  logic              grant_vld;
  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  logic              unused_addr_hi;
  assign unused_addr_hi = ^{a_addr[31:ADDR_W], b_addr[31:ADDR_W]};

  dmem_arb_pick u_pick (
    .a_req      (a_req),
    .b_req      (b_req),
    .prio_port  (prio_q),
    .grant_vld  (grant_vld),
    .grant_port (grant_port)
  );

  assign sel_we    = (grant_port == PORT_B) ? b_we                 : a_we;
  assign sel_addr  = (grant_port == PORT_B) ? b_addr[ADDR_W-1:0]   : a_addr[ADDR_W-1:0];
  assign sel_wdata = (grant_port == PORT_B) ? b_wdata              : a_wdata;
  assign next_beat = beat + 2'd1;

  // The last byte is still on mem_rdata during beat 3, so it is merged directly.
  assign word_done = we_q ? wdata_q : {rdata_q[31:8], mem_rdata};

  // Stage: request latch and read-byte assembly (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_vld) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
    if (state == XFER) begin
      rdata_q[{~beat, 3'b000} +: 8] <= mem_rdata;
    end
  end

  // Stage: control FSM and registered memory/response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= 2'd0;
      port_q    <= PORT_A;
      prio_q    <= PORT_A;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= 32'd0;
      b_rdata   <= 32'd0;
    end else begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= 32'd0;
      b_rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state     <= XFER;
            beat      <= 2'd0;
            port_q    <= grant_port;
            prio_q    <= ~grant_port;
            we_q      <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= byte_lane(sel_wdata, 2'd0);
            mem_we    <= sel_we;
          end
        end
        XFER: begin
          if (beat == 2'(BEATS - 1)) begin
            state     <= RESP;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            mem_we    <= 1'b0;
            if (port_q == PORT_B) begin
              b_ack   <= 1'b1;
              b_rdata <= word_done;
            end else begin
              a_ack   <= 1'b1;
              a_rdata <= word_done;
            end
          end else begin
            beat      <= next_beat;
            mem_addr  <= addr_q + ADDR_W'(next_beat);
            mem_wdata <= byte_lane(wdata_q, next_beat);
          end
        end
        RESP: begin
          state     <= IDLE;
          mem_addr  <= '0;
          mem_wdata <= 8'd0;
          mem_we    <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level model predicts grant order and words.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int ADDR_W = 8;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_req, a_we, b_req, b_we;
  logic [31:0]       a_addr, a_wdata, b_addr, b_wdata;
  logic [31:0]       a_rdata, b_rdata;
  logic              a_ack, b_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   we_cnt  = 0;
  logic m_prio;
  exp_t exp_q[$];
  txn_t idle_t = '{we: 1'b0, addr: 32'd0, wdata: 32'd0};

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_rdata   (a_rdata),
    .a_ack     (a_ack),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_rdata   (b_rdata),
    .b_ack     (b_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && mem_we) we_cnt <= we_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  // Reference: applies one word access to the byte image, big-endian with address wrap.
  task automatic apply(input txn_t t, output logic [31:0] word);
    logic [7:0] ad;
    for (int i = 0; i < 4; i++) begin
      ad = t.addr[7:0] + 8'(i);
      if (t.we) ref_mem[ad] = t.wdata[31 - 8*i -: 8];
      word[31 - 8*i -: 8] = ref_mem[ad];
    end
  endtask

  // Both requesters present their lists at once; predict service order and responses.
  task automatic model_push(input txn_t qa[$], input txn_t qb[$]);
    int   ia = 0;
    int   ib = 0;
    logic pick;
    exp_t e;
    while (ia < qa.size() || ib < qb.size()) begin
      if (ia >= qa.size())      pick = 1'b1;
      else if (ib >= qb.size()) pick = 1'b0;
      else                      pick = RR ? m_prio : 1'b0;
      m_prio = ~pick;
      e.port = pick;
      if (pick) begin apply(qb[ib], e.data); ib++; end
      else      begin apply(qa[ia], e.data); ia++; end
      exp_q.push_back(e);
    end
  endtask

  task automatic set_port(input logic port, input logic req, input txn_t t);
    if (port) begin
      b_req = req; b_we = t.we; b_addr = t.addr; b_wdata = t.wdata;
    end else begin
      a_req = req; a_we = t.we; a_addr = t.addr; a_wdata = t.wdata;
    end
  endtask

  task automatic drive(input logic port, input txn_t q[$], input bit chk_lat);
    int   c_ref;
    int   t;
    logic ack;
    c_ref = cyc;
    foreach (q[i]) begin
      set_port(port, 1'b1, q[i]);
      t = 0;
      do begin
        @(negedge clk);
        t++;
        ack = port ? b_ack : a_ack;
      end while (!ack && t < 80);
      if (!ack) begin
        n_tests++; n_fail++;
        $display("FAIL ack_timeout: port %0d got no ack within %0d cycles", port, t);
        break;
      end
      if (chk_lat) check(port ? "b_latency" : "a_latency", 32'(cyc - c_ref), (i == 0) ? 32'd5 : 32'd6);
      c_ref = cyc;
    end
    set_port(port, 1'b0, idle_t);
  endtask

  task automatic run_round(input txn_t qa[$], input txn_t qb[$], input bit chk_lat);
    model_push(qa, qb);
    fork
      drive(1'b0, qa, chk_lat);
      drive(1'b1, qb, chk_lat);
    join
    repeat (2) @(negedge clk);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = $urandom;
    t.wdata = $urandom;
    return t;
  endfunction

  // Monitor: every ack pops the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (a_ack || b_ack)) begin
      if ((a_ack && b_ack) || exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b pending=%0d", a_ack, b_ack, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        check("ack_port", 32'(b_ack), 32'(e.port));
        check("rdata", b_ack ? b_rdata : a_rdata, e.data);
        check("resp_mem_idle", 32'({mem_we, mem_addr, mem_wdata}), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t       qa[$];
    txn_t       qb[$];
    txn_t       t;
    logic [7:0] old22, old23;
    int         wc0, na, nb, nbad, tw;

    rst_n = 1'b0;
    m_prio = 1'b0;
    set_port(1'b0, 1'b0, idle_t);
    set_port(1'b1, 1'b0, idle_t);
    for (int i = 0; i < 256; i++) begin
      mem[i]     <= 8'(i * 7 + 3);
      ref_mem[i]  = 8'(i * 7 + 3);
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({a_ack, b_ack, mem_we, |mem_addr, |mem_wdata, |a_rdata, |b_rdata}), 32'd0);
    rst_n = 1'b1;

    // A store; first edge after reset release grants it
    t = '{we: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF};
    wc0 = we_cnt;
    qa = '{t}; qb = {};
    run_round(qa, qb, 1'b1);
    check("store_we_cycles", 32'(we_cnt - wc0), 32'd4);
    check("store_bytes_10", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEAD_BEEF);

    // B load of the same word
    t = '{we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0};
    qa = {}; qb = '{t};
    run_round(qa, qb, 1'b1);

    // Store wrapping past the top of memory, then read back with junk upper address bits
    t = '{we: 1'b1, addr: 32'h0000_00FE, wdata: 32'h1122_3344};
    qa = '{t}; qb = {};
    run_round(qa, qb, 1'b1);
    check("wrap_bytes", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'h1122_3344);
    t = '{we: 1'b0, addr: 32'hABCD_00FE, wdata: 32'h0};
    qa = {}; qb = '{t};
    run_round(qa, qb, 1'b1);

    // Simultaneous requests held across several transactions
    qa = {}; qb = {};
    for (int i = 0; i < 3; i++) qa.push_back(rand_txn());
    for (int i = 0; i < 2; i++) qb.push_back(rand_txn());
    run_round(qa, qb, 1'b0);

    // Inputs change / req drops mid-transfer: latched request still completes once
    t = '{we: 1'b1, addr: 32'h0000_0040, wdata: 32'hCAFE_F00D};
    qa = '{t}; qb = {};
    model_push(qa, qb);
    set_port(1'b0, 1'b1, t);
    repeat (2) @(negedge clk);
    a_req = 1'b0; a_we = 1'b0; a_addr = $urandom; a_wdata = $urandom;
    tw = 0;
    while (!a_ack && tw < 20) begin @(negedge clk); tw++; end
    check("latched_ack_seen", 32'(a_ack), 32'd1);
    repeat (10) @(negedge clk);
    check("latched_bytes_40", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hCAFE_F00D);

    // Reset during beat 2 of a store aborts the rest of the transfer
    old22 = mem[8'h22];
    old23 = mem[8'h23];
    t = '{we: 1'b1, addr: 32'h0000_0020, wdata: 32'hAABB_CCDD};
    set_port(1'b0, 1'b1, t);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    check("async_reset_outputs", 32'({a_ack, b_ack, mem_we, |mem_addr, |mem_wdata, |a_rdata, |b_rdata}), 32'd0);
    ref_mem[8'h20] = 8'hAA;
    ref_mem[8'h21] = 8'hBB;
    m_prio = 1'b0;
    @(negedge clk);
    check("abort_bytes_20", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, {8'hAA, 8'hBB, old22, old23});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomized rounds with mixed contention
    for (int r = 0; r < 40; r++) begin
      qa = {}; qb = {};
      na = $urandom_range(0, 2);
      nb = $urandom_range(0, 2);
      if (na == 0 && nb == 0) na = 1;
      for (int i = 0; i < na; i++) qa.push_back(rand_txn());
      for (int i = 0; i < nb; i++) qb.push_back(rand_txn());
      run_round(qa, qb, 1'b0);
      if (($urandom & 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("responses_outstanding", 32'(exp_q.size()), 32'd0);
    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (nbad == 0) $display("first memory difference at 0x%02h: 0x%02h vs model 0x%02h", i, mem[i], ref_mem[i]);
        nbad++;
      end
    end
    check("mem_image_diffs", 32'(nbad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
